// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button conditioning, IDLE/RUN/PAUSE FSM and 1 Hz tick prescaler
//
// Purpose:
//   Front-end control for the seconds BCD counter / 7-seg display path.
//   Raw push-buttons are synchronized and debounced, and their rising edges
//   drive the stopwatch FSM. A prescaler running only in RUN produces a
//   single-cycle tick every TICK_DIV RUN cycles. Downstream counting happens
//   on en & tick and clears on clr.
//
// Optional feature macro: STOPWATCH_LAP_EN (adds btn_lap / lap_hold).
//
// Ports:
//   clk        in   1  system clock, posedge
//   rst        in   1  synchronous reset, active-high
//   btn_start  in   1  raw async start/stop button, press toggles run/pause
//   btn_clear  in   1  raw async clear button, press returns to IDLE
//   btn_lap    in   1  raw async lap button (STOPWATCH_LAP_EN only)
//   lap_hold   out  1  display-freeze request (STOPWATCH_LAP_EN only)
//   tick       out  1  one-cycle pulse every TICK_DIV cycles spent in RUN
//   en         out  1  1 while state == RUN
//   clr        out  1  one-cycle pulse when a clear press is accepted
//   state      out  2  00 IDLE, 01 RUN, 10 PAUSE
`timescale 1ns/1ps

module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
  output logic       lap_hold,
`endif
  output logic       tick,
  output logic       en,
  output logic       clr,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  localparam int B_START = 0;
  localparam int B_CLEAR = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int B_LAP   = 2;
  localparam int NB      = 3;
`else
  localparam int NB      = 2;
`endif

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [NB-1:0] btn_raw;
`ifdef STOPWATCH_LAP_EN
  assign btn_raw = {btn_lap, btn_clear, btn_start};
`else
  assign btn_raw = {btn_clear, btn_start};
`endif

  // Input conditioning, one lane per button
  logic [NB-1:0] sync1_q, sync2_q, level_q, level_prev_q, press_q;
  logic [CNT_W-1:0] db_cnt_q [NB];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      // Edge detect on the registered level: press lands DEBOUNCE_CYCLES+3
      // cycles after a clean raw rise.
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          level_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stopwatch FSM with prescaler and registered outputs
  state_e           state_q;
  logic [CNT_W-1:0] presc_q;
  logic             tick_q, en_q, clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      clr_q  <= 1'b0;
      // Prescaler acts on the current state, so a tick due on the same edge
      // as a transition out of RUN is still emitted.
      if (state_q == S_RUN) begin
        if (presc_q == TICK_LAST) begin
          presc_q <= '0;
          tick_q  <= 1'b1;
        end else begin
          presc_q <= presc_q + CNT_W'(1);
        end
      end else if (state_q != S_PAUSE) begin
        presc_q <= '0;
      end
      // Clear has priority; a coincident start press is dropped.
      if (press_q[B_CLEAR]) begin
        state_q <= S_IDLE;
        en_q    <= 1'b0;
        clr_q   <= 1'b1;
        presc_q <= '0;
      end else if (press_q[B_START]) begin
        case (state_q)
          S_RUN: begin
            state_q <= S_PAUSE;
            en_q    <= 1'b0;
          end
          default: begin
            state_q <= S_RUN;
            en_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign state = state_q;
  assign tick  = tick_q;
  assign en    = en_q;
  assign clr   = clr_q;

`ifdef STOPWATCH_LAP_EN
  logic lap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q <= 1'b0;
    end else if (press_q[B_CLEAR]) begin
      lap_q <= 1'b0;
    end else if (press_q[B_LAP] && state_q == S_RUN) begin
      lap_q <= ~lap_q;
    end
  end

  assign lap_hold = lap_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap = 1'b0;
  logic       lap_hold;
`endif
  logic       tick, en, clr;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit model_ok = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (10),
    .CNT_W          (26)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_clear(btn_clear),
`ifdef STOPWATCH_LAP_EN
    .btn_lap  (btn_lap),
    .lap_hold (lap_hold),
`endif
    .tick     (tick),
    .en       (en),
    .clr      (clr),
    .state    (state)
  );

  // Reference model: a button is accepted once its raw value, seen through
  // two sync stages, has read the same new value on 4 consecutive edges;
  // the FSM reacts two edges after acceptance. Ticks fall on every 10th
  // edge spent in RUN since the watch last went to IDLE.
  logic [5:0] h [3];
  bit         lvl [3];
  bit         p1 [3];
  bit         p2 [3];
  bit         act [3];
  bit         raw [3];
  int         m_state;
  int         m_run;
  bit         e_tick, e_clr, m_lap;

  initial begin
    forever begin
      @(posedge clk);
      raw[0] = btn_start;
      raw[1] = btn_clear;
`ifdef STOPWATCH_LAP_EN
      raw[2] = btn_lap;
`else
      raw[2] = 1'b0;
`endif
      if (rst) begin
        for (int b = 0; b < 3; b++) begin
          h[b] = '0; lvl[b] = 0; p1[b] = 0; p2[b] = 0;
        end
        m_state = 0; m_run = 0; e_tick = 0; e_clr = 0; m_lap = 0;
        model_ok = 1'b1;
      end else begin
        for (int b = 0; b < 3; b++) begin
          act[b] = p2[b];
          p2[b]  = p1[b];
          h[b]   = {h[b][4:0], raw[b]};
          p1[b]  = 0;
          if (h[b][5:2] == 4'b1111 && !lvl[b]) begin
            lvl[b] = 1; p1[b] = 1;
          end else if (h[b][5:2] == 4'b0000 && lvl[b]) begin
            lvl[b] = 0;
          end
        end
        e_tick = 0;
        e_clr  = 0;
        if (m_state == 1) begin
          m_run++;
          if (m_run % 10 == 0) e_tick = 1;
        end
        if (act[1]) begin
          m_state = 0; e_clr = 1; m_lap = 0; m_run = 0;
        end else begin
`ifdef STOPWATCH_LAP_EN
          if (act[2] && m_state == 1) m_lap = !m_lap;
`endif
          if (act[0]) m_state = (m_state == 1) ? 2 : 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    logic [5:0] act_v, exp_v;
    logic       lap_v;
    forever begin
      @(negedge clk);
      if (model_ok) begin
`ifdef STOPWATCH_LAP_EN
        lap_v = lap_hold;
`else
        lap_v = 1'b0;
`endif
        act_v = {state, en, tick, clr, lap_v};
        exp_v = {m_state[1:0], (m_state == 1), e_tick, e_clr, m_lap};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL model_cmp cycle %0d: got {state,en,tick,clr,lap}=%b expected %b", cyc, act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, e, r, n;
    wait_until(2);
    rst = 1'b0;
    chk("reset_state", state, 0);
    chk("reset_en", en, 0);
    chk("reset_tick", tick, 0);
    chk("reset_clr", clr, 0);

    // Held press from IDLE: RUN 8 edges after the raw rise, ticks every 10
    m = cyc;
    btn_start = 1'b1;
    wait_until(m + 7);  chk("press_latency_en_low", en, 0);
    wait_until(m + 8);  chk("run_entry_en", en, 1); chk("run_entry_state", state, 1);
    wait_until(m + 12); btn_start = 1'b0;
    wait_until(m + 17); chk("tick_before_first", tick, 0);
    wait_until(m + 18); chk("first_tick", tick, 1);
    wait_until(m + 19); chk("tick_single_cycle", tick, 0);
    wait_until(m + 28); chk("second_tick", tick, 1);
    wait_until(m + 38); chk("third_tick", tick, 1);

    // Reset mid-RUN, landing on an edge where a tick is due
    wait_until(m + 47); rst = 1'b1;
    wait_until(m + 48); chk("rst_over_tick", tick, 0); chk("rst_state", state, 0);
    wait_until(m + 49); rst = 1'b0;
    chk("rst2_state", state, 0); chk("rst2_en", en, 0);
    chk("rst2_tick", tick, 0); chk("rst2_clr", clr, 0);

    // Glitches and bounce trains are rejected
    m = cyc;
    btn_start = 1'b1;
    wait_until(m + 3);  btn_start = 1'b0;
    wait_until(m + 12); chk("glitch3_state", state, 0);
    for (int i = 0; i < 8; i++) begin
      btn_start = (i % 2 == 0);
      btn_clear = (i % 2 == 1);
      wait_until(cyc + 1);
    end
    btn_start = 1'b0;
    btn_clear = 1'b1;
    wait_until(cyc + 3);
    btn_clear = 1'b0;
    wait_until(cyc + 12);
    chk("bounce_state", state, 0); chk("bounce_clr", clr, 0);

    // Exactly DEBOUNCE_CYCLES-long pulse is accepted; pause/resume keeps partial second
    m = cyc;
    btn_start = 1'b1;
    wait_until(m + 4);  btn_start = 1'b0;
    wait_until(m + 7);  chk("boundary_en_low", en, 0);
    wait_until(m + 8);  chk("boundary_accept_state", state, 1);
    e = m + 8;
    wait_until(e + 8);  btn_start = 1'b1;
    wait_until(e + 9);  chk("post_rst_tick_early", tick, 0);
    wait_until(e + 10); chk("post_rst_first_tick", tick, 1);
    wait_until(e + 14); btn_start = 1'b0;
    wait_until(e + 15); chk("pre_pause_state", state, 1);
    wait_until(e + 16); chk("pause_state", state, 2); chk("pause_en", en, 0);
    wait_until(e + 66); chk("pause_held_state", state, 2);
    r = e + 66;
    btn_start = 1'b1;
    wait_until(r + 6);  btn_start = 1'b0;
    wait_until(r + 8);  chk("resume_state", state, 1); chk("resume_en", en, 1);
    wait_until(r + 11); chk("resume_tick_early", tick, 0);
    wait_until(r + 12); chk("resume_first_tick", tick, 1);
    wait_until(r + 14); btn_start = 1'b1;
    wait_until(r + 20); btn_start = 1'b0;
    wait_until(r + 21); chk("pre_tickpause_state", state, 1);
    wait_until(r + 22); chk("tick_on_pause_edge", tick, 1); chk("tickpause_state", state, 2);
    wait_until(r + 24); btn_start = 1'b1;
    wait_until(r + 30); btn_start = 1'b0;
    wait_until(r + 32); chk("rerun_state", state, 1);

    // Start and clear together in RUN: clear wins
    m = cyc;
    wait_until(m + 3);  btn_start = 1'b1; btn_clear = 1'b1;
    wait_until(m + 9);  btn_start = 1'b0; btn_clear = 1'b0;
    wait_until(m + 10); chk("pre_clear_clr", clr, 0); chk("pre_clear_state", state, 1);
    wait_until(m + 11); chk("both_state", state, 0); chk("both_clr", clr, 1); chk("both_en", en, 0);
    wait_until(m + 12); chk("both_clr_single", clr, 0);
    wait_until(m + 25); chk("both_settled_state", state, 0);

    // Prescaler restarts from zero after clear
    n = cyc;
    btn_start = 1'b1;
    wait_until(n + 4);  btn_start = 1'b0;
    wait_until(n + 8);  chk("restart_state", state, 1);
    wait_until(n + 17); chk("restart_tick_early", tick, 0);
    wait_until(n + 18); chk("restart_first_tick", tick, 1);
`ifdef STOPWATCH_LAP_EN
    wait_until(n + 20); btn_lap = 1'b1;
    wait_until(n + 26); btn_lap = 1'b0;
    wait_until(n + 27); chk("lap_before", lap_hold, 0);
    wait_until(n + 28); chk("lap_set", lap_hold, 1); chk("lap_tick_continues", tick, 1);
    wait_until(n + 30); btn_lap = 1'b1;
    wait_until(n + 36); btn_lap = 1'b0;
    wait_until(n + 38); chk("lap_toggle_off", lap_hold, 0); chk("lap_off_tick", tick, 1);
    wait_until(n + 40); btn_lap = 1'b1;
    wait_until(n + 46); btn_lap = 1'b0;
    wait_until(n + 48); chk("lap_set_again", lap_hold, 1);
`endif
    wait_until(n + 50); btn_start = 1'b1;
    wait_until(n + 56); btn_start = 1'b0;
    wait_until(n + 58); chk("pause2_state", state, 2); chk("pause2_tick", tick, 1);
`ifdef STOPWATCH_LAP_EN
    chk("lap_kept_in_pause", lap_hold, 1);
    wait_until(n + 60); btn_lap = 1'b1;
    wait_until(n + 66); btn_lap = 1'b0;
    wait_until(n + 68); chk("lap_ignored_in_pause", lap_hold, 1);
`endif
    wait_until(n + 70); btn_clear = 1'b1;
    wait_until(n + 76); btn_clear = 1'b0;
    wait_until(n + 78); chk("clear_pause_state", state, 0); chk("clear_pause_clr", clr, 1);
`ifdef STOPWATCH_LAP_EN
    chk("clear_drops_lap", lap_hold, 0);
`endif
    wait_until(n + 80); btn_clear = 1'b1;
    wait_until(n + 86); btn_clear = 1'b0;
    wait_until(n + 87); chk("idle_clear_pre", clr, 0);
    wait_until(n + 88); chk("idle_clear_clr", clr, 1); chk("idle_clear_state", state, 0);
    wait_until(n + 89); chk("idle_clear_single", clr, 0);
    wait_until(n + 95);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
